register_file: RTL and testbench



---
 rtl/register_file_if.sv | 20 ++
 rtl/register_file.sv | 41 ++++
 tb/tb_register_file.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
interface register_file_if;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit architectural register file, $0 hardwired to zero, sync write, async read.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file (
  input logic            clk,
  input logic            reset,
  register_file_if.slave rf
);

  logic [31:0] regs [32];
  logic        wr_active;
  logic [31:0] data1;
  logic [31:0] data2;

  assign wr_active = rf.reg_write && (rf.write_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[rf.write_reg] <= rf.write_data;
    end
  end

  always_comb begin
    data1 = regs[rf.read_reg1];
    data2 = regs[rf.read_reg2];
`ifdef RF_BYPASS_EN
    // Forwarding is suppressed during reset, matching the write it would mirror.
    if (wr_active && !reset && (rf.read_reg1 == rf.write_reg)) data1 = rf.write_data;
    if (wr_active && !reset && (rf.read_reg2 == rf.write_reg)) data2 = rf.write_data;
`endif
    if (rf.read_reg1 == 5'd0) data1 = '0;
    if (rf.read_reg2 == 5'd0) data2 = '0;
  end

  assign rf.read_data1 = data1;
  assign rf.read_data2 = data2;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, a monitor checks it.
module tb_register_file;

  logic clk;
  logic reset;
  logic probe;

  register_file_if rf_bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_bus)
  );

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each falling edge where a probe is pending, pop and compare both ports.
  always @(negedge clk) begin
    if (probe) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL underflow: probe with empty queue");
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (rf_bus.read_data1 !== e.e1) begin
          fails++;
          $display("FAIL %s.rd1: got %08h expected %08h", e.name, rf_bus.read_data1, e.e1);
        end
        tests++;
        if (rf_bus.read_data2 !== e.e2) begin
          fails++;
          $display("FAIL %s.rd2: got %08h expected %08h", e.name, rf_bus.read_data2, e.e2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset             = rst;
    rf_bus.reg_write  = we;
    rf_bus.write_reg  = wa;
    rf_bus.write_data = wd;
    rf_bus.read_reg1  = r1;
    rf_bus.read_reg2  = r2;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
    probe = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    probe = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    step();

    // Every address reads zero after reset
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      expect_rd("reset_state", 32'h0, 32'h0);
      step();
    end

    // Reset clears a preloaded register
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    expect_rd("preload", 32'hDEADBEEF, 32'hDEADBEEF);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    expect_rd("reset_clear", 32'h0, 32'h0);
    step();

    // Basic write then read; neighbour untouched
    drive(1'b0, 1'b1, 5'd9, 32'h12345678, 5'd9, 5'd10);
    expect_rd("write_cycle", BYP ? 32'h12345678 : 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    expect_rd("basic_rw", 32'h12345678, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
    expect_rd("neighbour", 32'h0, 32'h12345678);
    step();

    // $0 write is discarded, including any forwarding
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd9);
    expect_rd("zero_same", 32'h0, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    expect_rd("zero_next", 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd10);
    expect_rd("zero_others", 32'h0, 32'h0);
    step();

    // Write enable low blocks the write
    drive(1'b0, 1'b0, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    expect_rd("we_gate_same", 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    expect_rd("we_gate", 32'h0, 32'h0);
    step();

    // Read during write, per-port independence
    drive(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b1, 5'd7, 32'h2, 5'd9, 5'd7);
    expect_rd("rdw", 32'h12345678, BYP ? 32'h2 : 32'h1);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    expect_rd("rdw_next", 32'h2, 32'h2);
    step();
    drive(1'b0, 1'b1, 5'd7, 32'h3, 5'd7, 5'd9);
    expect_rd("rdw_port1", BYP ? 32'h3 : 32'h2, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
    expect_rd("rdw_port1_next", 32'h3, 32'h12345678);
    step();

    // Reset beats a simultaneous write; no forwarding while in reset
    drive(1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd9);
    expect_rd("collide_same", 32'h0, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
    expect_rd("collide_after", 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd1, 5'd2);
    expect_rd("post_reset_w", 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    expect_rd("post_reset_rd", 32'hCAFEF00D, 32'hCAFEF00D);
    step();

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
